// File: rtl/snake_lcd_pkg.sv
// Shared definitions for the snake-game LCD path: bus widths, requester IDs,
// arbiter FSM encodings and small helpers for indexing the 3-requester vectors.
package snake_lcd_pkg;

  localparam int DEF_X_WIDTH    = 8;
  localparam int DEF_Y_WIDTH    = 9;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int NUM_REQ        = 3;

  localparam logic [1:0] REQ_BG     = 2'd0;
  localparam logic [1:0] REQ_SNAKE  = 2'd1;
  localparam logic [1:0] REQ_FOOD   = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Successor in the round-robin ring; GRANT_NONE wraps to the background.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    case (id)
      REQ_BG:    return REQ_SNAKE;
      REQ_SNAKE: return REQ_FOOD;
      default:   return REQ_BG;
    endcase
  endfunction

  function automatic logic req_bit(input logic [2:0] vec, input logic [1:0] id);
    case (id)
      REQ_BG:    return vec[0];
      REQ_SNAKE: return vec[1];
      REQ_FOOD:  return vec[2];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search over the three requesters, starting at the
// requester after the last winner.
module rr_priority_picker
  import snake_lcd_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] last,
  output logic [1:0] index,
  output logic       found
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0 = rr_next(last);
  assign w_c1 = rr_next(w_c0);
  assign w_c2 = rr_next(w_c1);

  always_comb begin
    index = w_c0;
    found = 1'b1;
    if (req_bit(valid, w_c0)) begin
      index = w_c0;
    end else if (req_bit(valid, w_c1)) begin
      index = w_c1;
    end else if (req_bit(valid, w_c2)) begin
      index = w_c2;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/lcd_pixel_arbiter.sv
// Arbitrates background/snake/food pixel writers onto one LT24 driver port,
// with round-robin fairness and an optional per-owner burst lock.
module lcd_pixel_arbiter
  import snake_lcd_pkg::*;
#(
  parameter int X_WIDTH    = DEF_X_WIDTH,
  parameter int Y_WIDTH    = DEF_Y_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetHW_n,
  input  logic [2:0]              req_valid,
  input  logic [2:0]              req_lock,
  input  logic [3*X_WIDTH-1:0]    req_x,
  input  logic [3*Y_WIDTH-1:0]    req_y,
  input  logic [3*DATA_WIDTH-1:0] req_data,
  output logic [2:0]              req_ack,
  output logic [1:0]              grant,
  input  logic                    pixelReady,
  output logic                    pixelWrite,
  output logic [X_WIDTH-1:0]      xAddr,
  output logic [Y_WIDTH-1:0]      yAddr,
  output logic [DATA_WIDTH-1:0]   pixelData
);

  state_t r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic       r_lock, w_lock_nxt;
  logic       r_wait_first, w_wait_first_nxt;
  logic [1:0] w_pick_idx, w_winner;
  logic       w_pick_found, w_owner_hit, w_accept;

  logic [X_WIDTH-1:0]    r_x, w_sel_x;
  logic [Y_WIDTH-1:0]    r_y, w_sel_y;
  logic [DATA_WIDTH-1:0] r_data, w_sel_data;

  rr_priority_picker u_picker (
    .valid (req_valid),
    .last  (r_last),
    .index (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_owner_hit = r_lock && req_bit(req_valid, r_grant);
  assign w_winner    = w_owner_hit ? r_grant : w_pick_idx;

  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 2'(i)) begin
        w_sel_x    = req_x[i*X_WIDTH +: X_WIDTH];
        w_sel_y    = req_y[i*Y_WIDTH +: Y_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_nxt       = r_last;
    w_lock_nxt       = r_lock;
    w_wait_first_nxt = 1'b0;
    w_accept         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_lock && !w_owner_hit) begin
          w_lock_nxt  = 1'b0;
          w_grant_nxt = GRANT_NONE;
        end
        if (pixelReady && (w_owner_hit || w_pick_found)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WRITE;
          w_grant_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_lock_nxt  = req_bit(req_lock, w_winner);
        end
      end
      ST_WRITE: begin
        w_state_nxt      = ST_WAIT;
        w_wait_first_nxt = 1'b1;
      end
      ST_WAIT: begin
        // The driver's ready may still be stale on the first WAIT cycle.
        if (!r_wait_first && pixelReady) begin
          w_state_nxt = ST_IDLE;
          if (!r_lock) w_grant_nxt = GRANT_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge resetHW_n) begin
    if (!resetHW_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_NONE;
      r_last       <= REQ_FOOD;
      r_lock       <= 1'b0;
      r_wait_first <= 1'b0;
      // NOTE: the pixel registers are plain flops, so clearing them on reset is cheap and makes outputs defined.
      r_x          <= '0;
      r_y          <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_lock       <= w_lock_nxt;
      r_wait_first <= w_wait_first_nxt;
      if (w_accept) begin
        r_x    <= w_sel_x;
        r_y    <= w_sel_y;
        r_data <= w_sel_data;
      end
    end
  end

  assign pixelWrite = (r_state == ST_WRITE);
  assign grant      = r_grant;
  assign xAddr      = r_x;
  assign yAddr      = r_y;
  assign pixelData  = r_data;

  always_comb begin
    req_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pixelWrite && (r_grant == 2'(i))) req_ack[i] = 1'b1;
    end
  end

endmodule
